// File: rtl/regfile_rename_pkg.sv
// Shared widths, sizes and sentinel values for the rename-aware register file.
package regfile_rename_pkg;

  localparam int REG_NUM  = 32;
  localparam int NICK_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NAME_W   = 5;
  localparam int CNT_W    = 32;

  // Nick 0 marks "no producer in flight"; register 0 is the hardwired zero.
  localparam int NO_NICK  = 0;
  localparam int ZERO_REG = 0;

  typedef logic [NICK_W-1:0] nick_t;
  typedef logic [NAME_W-1:0] name_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_rename_rd_port.sv
// One source-operand lookup: returns a ready value or the nick of its pending
// producer, with a same-cycle bypass from the commit stream.
module regfile_rename_rd_port
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM_P = REG_NUM,
  parameter int NICK_W_P  = NICK_W,
  parameter int DATA_W_P  = DATA_W
) (
  input  logic [NAME_W-1:0]   regnm,
  input  logic [DATA_W_P-1:0] val [REG_NUM_P],
  input  logic [NICK_W_P-1:0] tag [REG_NUM_P],
  input  logic                commit_en,
  input  logic [NICK_W_P-1:0] commit_nick,
  input  logic [DATA_W_P-1:0] commit_dt,
  output logic [DATA_W_P-1:0] dt,
  output logic [NICK_W_P-1:0] nick
);

  logic [DATA_W_P-1:0] sel_val;
  logic [NICK_W_P-1:0] sel_tag;
  logic                bypass_hit;

  assign sel_val = val[regnm];
  assign sel_tag = tag[regnm];

  // The committing entry produces exactly the pending value when its nick
  // matches the outstanding tag, so forward it without waiting a cycle.
  assign bypass_hit = (sel_tag != NICK_W_P'(NO_NICK)) && commit_en &&
                      (commit_nick == sel_tag);

  // Priority: zero register, then commit bypass, then stored value/tag.
  always_comb begin
    dt   = sel_val;
    nick = sel_tag;
    if (regnm == NAME_W'(ZERO_REG)) begin
      dt   = '0;
      nick = '0;
    end else if (bypass_hit) begin
      dt   = commit_dt;
      nick = '0;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags. Tracks the ROB
// rename stream, retires in-order commits, drops all tags on flush and serves
// two combinational source lookups to dispatch.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM_P = REG_NUM,
  parameter int NICK_W_P  = NICK_W,
  parameter int DATA_W_P  = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                iclr,
  input  logic                iROB_nick_en,
  input  logic [NICK_W_P-1:0] iROB_nick,
  input  logic [NAME_W-1:0]   iROB_nick_regnm,
  input  logic                iROB_en,
  input  logic [NAME_W-1:0]   iROB_rd_regnm,
  input  logic [DATA_W_P-1:0] iROB_rd_dt,
  input  logic [NICK_W_P-1:0] iROB_rd_nick,
  input  logic [NAME_W-1:0]   iDP_rs1_regnm,
  input  logic [NAME_W-1:0]   iDP_rs2_regnm,
  output logic [DATA_W_P-1:0] oDP_rs1_dt,
  output logic [NICK_W_P-1:0] oDP_rs1_nick,
  output logic [DATA_W_P-1:0] oDP_rs2_dt,
  output logic [NICK_W_P-1:0] oDP_rs2_nick,
  output logic [CNT_W-1:0]    oCommit_cnt
);

  logic [DATA_W_P-1:0] val_reg  [REG_NUM_P];
  logic [DATA_W_P-1:0] val_next [REG_NUM_P];
  logic [NICK_W_P-1:0] tag_reg  [REG_NUM_P];
  logic [NICK_W_P-1:0] tag_next [REG_NUM_P];
  logic [CNT_W-1:0]    commit_cnt_reg;

  // Per-register next state. Register 0 never matches a write, so it holds
  // its reset value of zero forever.
  generate
    for (genvar gi = 0; gi < REG_NUM_P; gi++) begin : g_reg
      logic commit_hit;
      logic rename_hit;
      logic tag_retire;

      assign commit_hit = iROB_en && (gi != ZERO_REG) &&
                          (iROB_rd_regnm == NAME_W'(gi));
      assign rename_hit = iROB_nick_en && (gi != ZERO_REG) &&
                          (iROB_nick_regnm == NAME_W'(gi));
      // Only the commit of the youngest rename frees the register; an older
      // commit leaves a newer pending tag in place.
      assign tag_retire = commit_hit && (tag_reg[gi] == iROB_rd_nick);

      assign val_next[gi] = commit_hit ? iROB_rd_dt : val_reg[gi];
      // Flush beats rename (in-flight rename is squashed); rename beats retire.
      assign tag_next[gi] = iclr       ? NICK_W_P'(NO_NICK) :
                            rename_hit ? iROB_nick          :
                            tag_retire ? NICK_W_P'(NO_NICK) :
                                         tag_reg[gi];
    end
  endgenerate

  // State update: async clear, otherwise advance only when rdy is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM_P; i++) begin
        val_reg[i] <= '0;
        tag_reg[i] <= '0;
      end
      commit_cnt_reg <= '0;
    end else if (rdy) begin
      for (int i = 0; i < REG_NUM_P; i++) begin
        val_reg[i] <= val_next[i];
        tag_reg[i] <= tag_next[i];
      end
      if (iROB_en) begin
        commit_cnt_reg <= commit_cnt_reg + 1'b1;
      end
    end
  end

  assign oCommit_cnt = commit_cnt_reg;

  regfile_rename_rd_port #(
    .REG_NUM_P (REG_NUM_P),
    .NICK_W_P  (NICK_W_P),
    .DATA_W_P  (DATA_W_P)
  ) u_rs1_port (
    .regnm       (iDP_rs1_regnm),
    .val         (val_reg),
    .tag         (tag_reg),
    .commit_en   (iROB_en),
    .commit_nick (iROB_rd_nick),
    .commit_dt   (iROB_rd_dt),
    .dt          (oDP_rs1_dt),
    .nick        (oDP_rs1_nick)
  );

  regfile_rename_rd_port #(
    .REG_NUM_P (REG_NUM_P),
    .NICK_W_P  (NICK_W_P),
    .DATA_W_P  (DATA_W_P)
  ) u_rs2_port (
    .regnm       (iDP_rs2_regnm),
    .val         (val_reg),
    .tag         (tag_reg),
    .commit_en   (iROB_en),
    .commit_nick (iROB_rd_nick),
    .commit_dt   (iROB_rd_dt),
    .dt          (oDP_rs2_dt),
    .nick        (oDP_rs2_nick)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed plus randomized bench for regfile_rename against an array-based
// reference model of the register file.
module tb_regfile_rename;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        iclr;
  logic        iROB_nick_en;
  logic [4:0]  iROB_nick;
  logic [4:0]  iROB_nick_regnm;
  logic        iROB_en;
  logic [4:0]  iROB_rd_regnm;
  logic [31:0] iROB_rd_dt;
  logic [4:0]  iROB_rd_nick;
  logic [4:0]  iDP_rs1_regnm;
  logic [4:0]  iDP_rs2_regnm;
  logic [31:0] oDP_rs1_dt;
  logic [4:0]  oDP_rs1_nick;
  logic [31:0] oDP_rs2_dt;
  logic [4:0]  oDP_rs2_nick;
  logic [31:0] oCommit_cnt;

  regfile_rename dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .iclr            (iclr),
    .iROB_nick_en    (iROB_nick_en),
    .iROB_nick       (iROB_nick),
    .iROB_nick_regnm (iROB_nick_regnm),
    .iROB_en         (iROB_en),
    .iROB_rd_regnm   (iROB_rd_regnm),
    .iROB_rd_dt      (iROB_rd_dt),
    .iROB_rd_nick    (iROB_rd_nick),
    .iDP_rs1_regnm   (iDP_rs1_regnm),
    .iDP_rs2_regnm   (iDP_rs2_regnm),
    .oDP_rs1_dt      (oDP_rs1_dt),
    .oDP_rs1_nick    (oDP_rs1_nick),
    .oDP_rs2_dt      (oDP_rs2_dt),
    .oDP_rs2_nick    (oDP_rs2_nick),
    .oCommit_cnt     (oCommit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural values, pending producer per register,
  // and the number of accepted commits.
  logic [31:0] mval [32];
  logic [4:0]  mtag [32];
  logic [31:0] mcnt;

  int n_pass  = 0;
  int n_total = 0;
  int n_step  = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0;
      mtag[i] = '0;
    end
    mcnt = '0;
  endtask

  // What dispatch should see for register r given the commit on the bus now.
  task automatic model_read(input logic [4:0] r, output logic [31:0] d,
                            output logic [4:0] n);
    if (r == 5'd0) begin
      d = '0;
      n = '0;
    end else if (mtag[r] != 5'd0 && iROB_en && iROB_rd_nick == mtag[r]) begin
      d = iROB_rd_dt;
      n = '0;
    end else begin
      d = mval[r];
      n = mtag[r];
    end
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    if (!rdy) return;
    if (iROB_en) begin
      if (iROB_rd_regnm != 5'd0) begin
        mval[iROB_rd_regnm] = iROB_rd_dt;
        if (mtag[iROB_rd_regnm] == iROB_rd_nick) mtag[iROB_rd_regnm] = '0;
      end
      mcnt = mcnt + 32'd1;
    end
    if (iclr) begin
      for (int i = 0; i < 32; i++) mtag[i] = '0;
    end else if (iROB_nick_en && iROB_nick_regnm != 5'd0) begin
      mtag[iROB_nick_regnm] = iROB_nick;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic idle();
    rdy             = 1'b1;
    iclr            = 1'b0;
    iROB_nick_en    = 1'b0;
    iROB_nick       = '0;
    iROB_nick_regnm = '0;
    iROB_en         = 1'b0;
    iROB_rd_regnm   = '0;
    iROB_rd_dt      = '0;
    iROB_rd_nick    = '0;
    iDP_rs1_regnm   = '0;
    iDP_rs2_regnm   = '0;
  endtask

  // One transaction: check reads against the model mid-cycle, clock it,
  // then advance the model. Called at posedge+1 and returns at posedge+1.
  task automatic step(input string what);
    logic [31:0] d1, d2;
    logic [4:0]  n1, n2;
    #1;
    model_read(iDP_rs1_regnm, d1, n1);
    model_read(iDP_rs2_regnm, d2, n2);
    chk({what, "_rs1_dt"},   oDP_rs1_dt,   d1);
    chk({what, "_rs1_nick"}, {27'd0, oDP_rs1_nick}, {27'd0, n1});
    chk({what, "_rs2_dt"},   oDP_rs2_dt,   d2);
    chk({what, "_rs2_nick"}, {27'd0, oDP_rs2_nick}, {27'd0, n2});
    chk({what, "_cnt"},      oCommit_cnt,  mcnt);
    $display("txn %0d %s rdy=%0b clr=%0b ren=%0b x%0d<-n%0d com=%0b x%0d=%h n%0d rs1=x%0d:%h/%0d rs2=x%0d:%h/%0d cnt=%0d",
             n_step, what, rdy, iclr, iROB_nick_en, iROB_nick_regnm, iROB_nick,
             iROB_en, iROB_rd_regnm, iROB_rd_dt, iROB_rd_nick,
             iDP_rs1_regnm, oDP_rs1_dt, oDP_rs1_nick,
             iDP_rs2_regnm, oDP_rs2_dt, oDP_rs2_nick, oCommit_cnt);
    n_step++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    idle(); iDP_rs1_regnm = 5'd5; iDP_rs2_regnm = 5'd0;
    #1;
    chk("rst_rs1_dt", oDP_rs1_dt, 32'd0);
    chk("rst_rs1_nick", {27'd0, oDP_rs1_nick}, 32'd0);
    chk("rst_cnt", oCommit_cnt, 32'd0);
    step("reset");

    // Rename, then commit with same-cycle bypass
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd3; iROB_nick_regnm = 5'd5;
    step("ren_x5");
    idle(); iDP_rs1_regnm = 5'd5;
    #1;
    chk("x5_pending_nick", {27'd0, oDP_rs1_nick}, 32'd3);
    step("read_x5");
    idle(); iROB_en = 1'b1; iROB_rd_regnm = 5'd5; iROB_rd_dt = 32'hDEADBEEF;
    iROB_rd_nick = 5'd3; iDP_rs1_regnm = 5'd5;
    #1;
    chk("x5_bypass_dt", oDP_rs1_dt, 32'hDEADBEEF);
    chk("x5_bypass_nick", {27'd0, oDP_rs1_nick}, 32'd0);
    step("com_x5");
    idle(); iDP_rs1_regnm = 5'd5;
    #1;
    chk("x5_val", oDP_rs1_dt, 32'hDEADBEEF);
    chk("x5_tag", {27'd0, oDP_rs1_nick}, 32'd0);
    chk("cnt_1", oCommit_cnt, 32'd1);
    step("read_x5b");

    // Older commit must not free a younger rename
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd4; iROB_nick_regnm = 5'd7;
    step("ren_x7a");
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd9; iROB_nick_regnm = 5'd7;
    step("ren_x7b");
    idle(); iROB_en = 1'b1; iROB_rd_regnm = 5'd7; iROB_rd_dt = 32'h11;
    iROB_rd_nick = 5'd4; iDP_rs2_regnm = 5'd7;
    #1;
    chk("x7_no_bypass_nick", {27'd0, oDP_rs2_nick}, 32'd9);
    step("com_x7");
    idle(); iDP_rs2_regnm = 5'd7;
    #1;
    chk("x7_val", oDP_rs2_dt, 32'h11);
    chk("x7_tag_kept", {27'd0, oDP_rs2_nick}, 32'd9);
    step("read_x7");

    // Rename and commit on the same register in one cycle
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd6; iROB_nick_regnm = 5'd8;
    iROB_en = 1'b1; iROB_rd_regnm = 5'd8; iROB_rd_dt = 32'h22; iROB_rd_nick = 5'd2;
    step("ren_com_x8");
    idle(); iDP_rs1_regnm = 5'd8;
    #1;
    chk("x8_val", oDP_rs1_dt, 32'h22);
    chk("x8_tag", {27'd0, oDP_rs1_nick}, 32'd6);
    step("read_x8");

    // Flush: commit kept, same-cycle rename dropped, all tags cleared
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd1; iROB_nick_regnm = 5'd1;
    step("ren_x1");
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd2; iROB_nick_regnm = 5'd2;
    step("ren_x2");
    idle(); iclr = 1'b1; iROB_en = 1'b1; iROB_rd_regnm = 5'd1; iROB_rd_dt = 32'h5;
    iROB_rd_nick = 5'd1; iROB_nick_en = 1'b1; iROB_nick = 5'd3; iROB_nick_regnm = 5'd3;
    iDP_rs1_regnm = 5'd1;
    step("clr");
    idle(); iDP_rs1_regnm = 5'd1; iDP_rs2_regnm = 5'd3;
    #1;
    chk("clr_x1_val", oDP_rs1_dt, 32'h5);
    chk("clr_x3_tag", {27'd0, oDP_rs2_nick}, 32'd0);
    step("read_x1_x3");
    idle(); iDP_rs1_regnm = 5'd2; iDP_rs2_regnm = 5'd8;
    #1;
    chk("clr_x2_tag", {27'd0, oDP_rs1_nick}, 32'd0);
    chk("clr_x8_tag", {27'd0, oDP_rs2_nick}, 32'd0);
    step("read_x2_x8");

    // rdy low: nothing moves, reads stay live (bypass still visible)
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd12; iROB_nick_regnm = 5'd9;
    step("ren_x9");
    idle(); rdy = 1'b0; iclr = 1'b1; iROB_en = 1'b1; iROB_rd_regnm = 5'd9;
    iROB_rd_dt = 32'hAB; iROB_rd_nick = 5'd12; iROB_nick_en = 1'b1;
    iROB_nick = 5'd5; iROB_nick_regnm = 5'd4; iDP_rs1_regnm = 5'd9;
    #1;
    chk("stall_bypass_dt", oDP_rs1_dt, 32'hAB);
    step("stall");
    idle(); iDP_rs1_regnm = 5'd9; iDP_rs2_regnm = 5'd4;
    #1;
    chk("stall_x9_tag", {27'd0, oDP_rs1_nick}, 32'd12);
    chk("stall_x9_val", oDP_rs1_dt, 32'd0);
    chk("stall_x4_tag", {27'd0, oDP_rs2_nick}, 32'd0);
    chk("stall_cnt", oCommit_cnt, 32'd4);
    step("read_x9_x4");

    // x0 writes: ignored except for the counter
    idle(); iROB_nick_en = 1'b1; iROB_nick = 5'd7; iROB_nick_regnm = 5'd0;
    iROB_en = 1'b1; iROB_rd_regnm = 5'd0; iROB_rd_dt = 32'hFF; iROB_rd_nick = 5'd7;
    step("x0_write");
    idle();
    #1;
    chk("x0_dt", oDP_rs1_dt, 32'd0);
    chk("x0_nick", {27'd0, oDP_rs1_nick}, 32'd0);
    chk("x0_cnt", oCommit_cnt, 32'd5);
    step("read_x0");

    // Randomized traffic on a small register window for frequent collisions
    for (int c = 0; c < 400; c++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 7));
      rdy             = ($urandom_range(0, 9) != 0);
      iclr            = ($urandom_range(0, 19) == 0);
      iROB_nick_en    = 1'($urandom_range(0, 1));
      iROB_nick       = 5'($urandom_range(1, 31));
      iROB_nick_regnm = 5'($urandom_range(0, 7));
      iROB_en         = 1'($urandom_range(0, 1));
      iROB_rd_regnm   = rd;
      iROB_rd_dt      = $urandom;
      iROB_rd_nick    = ($urandom_range(0, 2) != 0 && mtag[rd] != 5'd0) ?
                        mtag[rd] : 5'($urandom_range(1, 31));
      iDP_rs1_regnm   = 5'($urandom_range(0, 7));
      iDP_rs2_regnm   = 5'($urandom_range(0, 7));
      step("rand");
    end

    // Asynchronous reset pulse between clock edges
    idle(); iDP_rs1_regnm = 5'd5; iDP_rs2_regnm = 5'd7;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_rs1_dt", oDP_rs1_dt, 32'd0);
    chk("arst_rs1_nick", {27'd0, oDP_rs1_nick}, 32'd0);
    chk("arst_rs2_dt", oDP_rs2_dt, 32'd0);
    chk("arst_rs2_nick", {27'd0, oDP_rs2_nick}, 32'd0);
    chk("arst_cnt", oCommit_cnt, 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(); iROB_en = 1'b1; iROB_rd_regnm = 5'd5; iROB_rd_dt = 32'h1234;
    iROB_rd_nick = 5'd1; iDP_rs1_regnm = 5'd5;
    step("post_rst_com");
    idle(); iDP_rs1_regnm = 5'd5;
    step("post_rst_read");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
Architectural register file with per-register rename tags, directly downstream of the ROB. It consumes the ROB's nick-allocation stream and its in-order commit stream, and serves two combinational source-operand lookups to dispatch. Each lookup returns either a ready value or the ROB nick that will produce it. On a ROB flush, all rename tags are dropped and committed values are kept.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
NICK_W, 5, ROB nick width; nick 0 means "no producer", valid nicks are 1..31
DATA_W, 32, register data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global enable; when low, state holds
iclr  in  1  ROB flush, sampled at posedge
iROB_nick_en  in  1  rename request
iROB_nick  in  NICK_W  nick allocated to the instruction
iROB_nick_regnm  in  5  destination register being renamed
iROB_en  in  1  commit write
iROB_rd_regnm  in  5  commit destination register
iROB_rd_dt  in  DATA_W  commit value
iROB_rd_nick  in  NICK_W  nick of the committing entry
iDP_rs1_regnm  in  5  source 1 register
iDP_rs2_regnm  in  5  source 2 register
oDP_rs1_dt  out  DATA_W  source 1 value (valid when oDP_rs1_nick==0)
oDP_rs1_nick  out  NICK_W  source 1 pending producer, 0 = ready
oDP_rs2_dt  out  DATA_W  source 2 value
oDP_rs2_nick  out  NICK_W  source 2 pending producer
oCommit_cnt  out  32  number of commit writes accepted since reset

Behaviour:
- State: val[0..31], tag[0..31] (NICK_W each), commit counter. Reset (rst=0, async) sets all val=0, all tag=0, oCommit_cnt=0.
- Read ports are combinational from current state plus a commit bypass. Per port, with r = rs_regnm:
  - r==0 -> dt=0, nick=0.
  - else if tag[r]!=0 and iROB_en and iROB_rd_nick==tag[r] -> dt=iROB_rd_dt, nick=0 (same-cycle bypass).
  - else dt=val[r], nick=tag[r].
- Reads never reflect the same-cycle rename: an instruction's own rd does not alias its sources.
- Commit (posedge, rdy=1, iROB_en=1, iROB_rd_regnm!=0):
  - val[rd] <= iROB_rd_dt; oCommit_cnt increments (wraps at 2^32).
  - tag[rd] <= 0 only when tag[rd]==iROB_rd_nick; otherwise a younger rename is still pending and the tag is kept.
- Commit to x0: no state change; the counter still increments.
- Rename (posedge, rdy=1, iclr=0, iROB_nick_en=1, regnm!=0): tag[regnm] <= iROB_nick. Rename of x0 is ignored.
- Rename and commit to the same register in the same cycle: the rename tag wins and the value is still written.
- iclr=1 at posedge (rdy=1): all tag <= 0. The commit write in that cycle is still performed; the rename in that cycle is dropped. Values are untouched.
- rdy=0: no state update (commit, rename, clr and counter all ignored). Read outputs remain live.
- Latency: writes are visible on the read ports the cycle after the edge. The only same-cycle visibility is the commit bypass.
- Reset mid-operation: immediate clear regardless of clk or rdy.

Decomposition:
- Shared config include gets: NickBus, NameBus, DataBus ranges; RegNum=32; NoNick=0; ZeroReg=0.
- One sub-module, regfile_rd_port: the purely combinational lookup plus bypass, instantiated twice (rs1, rs2).
- Storage, rename, commit and flush logic stay in the top.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> dt=0, nick=0 on both; oCommit_cnt=0.
- Rename x5->nick 3; next cycle read rs1=5 -> nick=3. Commit x5=0xDEADBEEF nick 3 with rs1=5 in the same cycle -> bypass dt=0xDEADBEEF, nick=0. Following cycle: val[5]=0xDEADBEEF, tag=0, oCommit_cnt=1.
- Rename x7->nick 4, then x7->nick 9; commit x7=0x11 nick 4 -> val[7]=0x11, tag[7] stays 9; read rs2=7 returns nick=9.
- Rename x8->nick 6 and commit x8=0x22 nick 2 in the same cycle -> val[8]=0x22, tag[8]=6.
- Rename x1->nick 1, x2->nick 2; assert iclr with commit x1=0x5 nick 1 and rename x3->nick 3 -> tags all 0, val[1]=0x5, x3 not renamed.
- Rename x0->nick 7 and commit x0=0xFF -> read rs1=0 gives 0/0 and counter increments. Pulse rst low mid-stream (between edges) -> outputs clear immediately.
